// File: rtl/poly_coeff_streamer_if.sv
// Coefficient load/stream bundle for poly_coeff_streamer: polynomial load side and
// LANES-wide output beat side with valid/ack back-pressure.
interface poly_coeff_streamer_if #(
    parameter int BIT_WIDTH = 32,
    parameter int DEGREE_N  = 8,
    parameter int LANES     = 1
);
    localparam int IDX_W = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;

    logic [BIT_WIDTH-1:0]                t;
    logic [BIT_WIDTH-1:0]                q;
    logic [1:0]                          mode_i;
    logic [DEGREE_N-1:0][BIT_WIDTH-1:0]  coeff_i;
    logic                                coeff_ready_i;
    logic                                in_ready_o;
    logic                                overflow_o;
    logic [LANES-1:0][BIT_WIDTH-1:0]     coeff_o;
    logic                                coeff_ready_o;
    logic                                coeff_ack_i;
    logic [IDX_W-1:0]                    coeff_idx_o;
    logic                                poly_last_o;

    modport master (
        output t, q, mode_i, coeff_i, coeff_ready_i, coeff_ack_i,
        input  in_ready_o, overflow_o, coeff_o, coeff_ready_o, coeff_idx_o, poly_last_o
    );

    modport slave (
        input  t, q, mode_i, coeff_i, coeff_ready_i, coeff_ack_i,
        output in_ready_o, overflow_o, coeff_o, coeff_ready_o, coeff_idx_o, poly_last_o
    );
endinterface

// File: rtl/poly_coeff_streamer.sv
// Two-slot ping-pong polynomial buffer applying reduce/add-t/negate mod q; first beat valid one
// cycle after load. Output register holds under coeff_ack_i low; loads are dropped (sticky overflow) when both slots are full.
module poly_coeff_streamer #(
    parameter int BIT_WIDTH = 32,
    parameter int DEGREE_N  = 8,
    parameter int LANES     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    poly_coeff_streamer_if.slave   bus
);
    localparam int BEATS  = DEGREE_N / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int IDX_W  = (DEGREE_N > 1) ? $clog2(DEGREE_N) : 1;
    localparam int CW     = BIT_WIDTH + 1;

    typedef struct packed {
        logic [DEGREE_N-1:0][BIT_WIDTH-1:0] coeff;
        logic [BIT_WIDTH-1:0]               t;
        logic [BIT_WIDTH-1:0]               q;
        logic [1:0]                         mode;
    } slot_t;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    slot_t                          slot_q [2];
    slot_t                          slot_d [2];
    logic [1:0]                     occ_q, occ_d;
    logic                           wr_ptr_q, wr_ptr_d;
    logic                           rd_ptr_q, rd_ptr_d;
    state_t                         state_q, state_d;
    logic [BEAT_W-1:0]              beat_q, beat_d;
    logic                           ovf_q, ovf_d;
    logic [LANES-1:0][BIT_WIDTH-1:0] dat_q, dat_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic                           last_q, last_d;

    logic                           in_ready;
    logic                           fetch;
    logic                           src;
    logic [BEAT_W-1:0]              src_beat;

    function automatic logic [BIT_WIDTH-1:0] mod_op(
        input logic [BIT_WIDTH-1:0] c,
        input logic [BIT_WIDTH-1:0] tv,
        input logic [BIT_WIDTH-1:0] qv,
        input logic [1:0]           mode
    );
        logic [CW-1:0]        cx, tx, qx, s;
        logic [BIT_WIDTH-1:0] r;
        cx = {1'b0, c};
        tx = {1'b0, tv};
        qx = {1'b0, qv};
        s  = cx + tx;
        case (mode)
            2'd1:    r = (s >= qx) ? BIT_WIDTH'(s - qx) : BIT_WIDTH'(s);
            2'd2:    r = (cx == '0) ? '0 : BIT_WIDTH'(qx - cx);
            default: r = (cx >= qx) ? BIT_WIDTH'(cx - qx) : BIT_WIDTH'(cx);
        endcase
        return r;
    endfunction

    assign in_ready = ~(&occ_q);

    always_comb begin
        slot_d   = slot_q;
        occ_d    = occ_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        state_d  = state_q;
        beat_d   = beat_q;
        ovf_d    = ovf_q;
        dat_d    = dat_q;
        idx_d    = idx_q;
        last_d   = last_q;
        fetch    = 1'b0;
        src      = rd_ptr_q;
        src_beat = '0;

        if (bus.coeff_ready_i) begin
            if (in_ready) begin
                slot_d[wr_ptr_q] = '{coeff: bus.coeff_i, t: bus.t, q: bus.q, mode: bus.mode_i};
                occ_d[wr_ptr_q]  = 1'b1;
                wr_ptr_d         = ~wr_ptr_q;
            end else begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (occ_q[rd_ptr_q]) begin
                    fetch   = 1'b1;
                    state_d = S_STREAM;
                    beat_d  = '0;
                end
            end
            S_STREAM: begin
                if (bus.coeff_ack_i) begin
                    if (beat_q != BEAT_W'(BEATS - 1)) begin
                        fetch    = 1'b1;
                        src_beat = beat_q + 1'b1;
                        beat_d   = beat_q + 1'b1;
                    end else begin
                        // Last beat retires the slot; the other slot, if full, follows without a bubble.
                        occ_d[rd_ptr_q] = 1'b0;
                        rd_ptr_d        = ~rd_ptr_q;
                        beat_d          = '0;
                        if (occ_q[~rd_ptr_q]) begin
                            fetch = 1'b1;
                            src   = ~rd_ptr_q;
                        end else begin
                            state_d = S_IDLE;
                            last_d  = 1'b0;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (fetch) begin
            for (int j = 0; j < LANES; j++) begin
                dat_d[j] = mod_op(slot_q[src].coeff[IDX_W'(int'(src_beat) * LANES + j)],
                                  slot_q[src].t, slot_q[src].q, slot_q[src].mode);
            end
            idx_d  = IDX_W'(int'(src_beat) * LANES);
            last_d = (src_beat == BEAT_W'(BEATS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            state_q  <= S_IDLE;
            beat_q   <= '0;
            ovf_q    <= 1'b0;
            dat_q    <= '0;
            idx_q    <= '0;
            last_q   <= 1'b0;
        end else begin
            occ_q    <= occ_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            state_q  <= state_d;
            beat_q   <= beat_d;
            ovf_q    <= ovf_d;
            dat_q    <= dat_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
        end
    end

    // Slot payload is qualified by occ_q, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

    assign bus.in_ready_o    = in_ready;
    assign bus.overflow_o    = ovf_q;
    assign bus.coeff_o       = dat_q;
    assign bus.coeff_ready_o = (state_q == S_STREAM);
    assign bus.coeff_idx_o   = idx_q;
    assign bus.poly_last_o   = last_q;
endmodule

// File: tb/tb_poly_coeff_streamer.sv
// Scenario bench for poly_coeff_streamer: LANES=1 and LANES=2 instances, scoreboard queues
// filled at load time and drained on each accepted output beat.
module tb_poly_coeff_streamer;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    poly_coeff_streamer_if #(.BIT_WIDTH(32), .DEGREE_N(8), .LANES(1)) a_if ();
    poly_coeff_streamer_if #(.BIT_WIDTH(32), .DEGREE_N(8), .LANES(2)) b_if ();

    poly_coeff_streamer #(.BIT_WIDTH(32), .DEGREE_N(8), .LANES(1)) u_a (.clk(clk), .rst(rst), .bus(a_if));
    poly_coeff_streamer #(.BIT_WIDTH(32), .DEGREE_N(8), .LANES(2)) u_b (.clk(clk), .rst(rst), .bus(b_if));

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] v; logic [2:0] idx; logic last; } exp_t;
    typedef struct { logic [31:0] v0; logic [31:0] v1; logic [2:0] idx; logic last; } exp2_t;
    exp_t  sb  [$];
    exp2_t sb2 [$];

    int vec_m0 [8] = '{0, 20, 21, 41, 5, 22, 40, 1};
    int exp_m0 [8] = '{0, 20, 0, 20, 5, 1, 19, 1};
    int vec_m1 [8] = '{18, 3, 0, 15, 16, 20, 1, 10};
    int exp_m1 [8] = '{2, 8, 5, 20, 0, 4, 6, 15};
    int exp_m2 [8] = '{3, 18, 0, 6, 5, 1, 20, 11};
    int vec_r  [8] = '{7, 1, 2, 3, 4, 5, 6, 8};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input int v[8], input int tt, input int qq, input int md);
        for (int i = 0; i < 8; i++) a_if.coeff_i[i] = 32'(v[i]);
        a_if.t      = 32'(tt);
        a_if.q      = 32'(qq);
        a_if.mode_i = 2'(md);
    endtask

    task automatic push_a(input int e[8]);
        for (int i = 0; i < 8; i++) sb.push_back('{v: 32'(e[i]), idx: 3'(i), last: (i == 7)});
    endtask

    task automatic test_reset;
        rst = 1'b1;
        a_if.coeff_i = '0; a_if.t = '0; a_if.q = 32'd21; a_if.mode_i = '0;
        a_if.coeff_ready_i = 1'b0; a_if.coeff_ack_i = 1'b0;
        b_if.coeff_i = '0; b_if.t = '0; b_if.q = 32'd21; b_if.mode_i = '0;
        b_if.coeff_ready_i = 1'b0; b_if.coeff_ack_i = 1'b0;
        tick; tick;
        rst = 1'b0;
        tick;
        total++; if (a_if.in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", a_if.in_ready_o); end
        total++; if (a_if.overflow_o !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%0b want=0", a_if.overflow_o); end
        total++; if (a_if.coeff_ready_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", a_if.coeff_ready_o); end
        total++; if (a_if.poly_last_o !== 1'b0) begin bad++; $display("FAIL reset_last got=%0b want=0", a_if.poly_last_o); end
        total++; if (a_if.coeff_o !== 32'd0) begin bad++; $display("FAIL reset_coeff got=%0d want=0", a_if.coeff_o); end
        total++; if (a_if.coeff_idx_o !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", a_if.coeff_idx_o); end
        total++; if (b_if.coeff_ready_o !== 1'b0 || b_if.in_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_lanes2 got valid=%0b rdy=%0b want valid=0 rdy=1", b_if.coeff_ready_o, b_if.in_ready_o);
        end
    endtask

    task automatic test_mode0;
        exp_t e;
        int   n = 0;
        drive_a(vec_m0, 0, 21, 0);
        push_a(exp_m0);
        a_if.coeff_ack_i   = 1'b1;
        a_if.coeff_ready_i = 1'b1;
        tick;
        a_if.coeff_ready_i = 1'b0;
        total++; if (a_if.coeff_ready_o !== 1'b0) begin bad++; $display("FAIL latency_e0 valid got=%0b want=0", a_if.coeff_ready_o); end
        tick;
        total++; if (a_if.coeff_ready_o !== 1'b1) begin bad++; $display("FAIL latency_e1 valid got=%0b want=1", a_if.coeff_ready_o); end
        while (sb.size() != 0 && n < 40) begin
            if (a_if.coeff_ready_o) begin
                e = sb.pop_front();
                total++;
                if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o} !== {e.v, e.idx, e.last}) begin
                    bad++; $display("FAIL mode0_beat got=%0d/idx%0d/last%0b want=%0d/idx%0d/last%0b",
                                    a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, e.v, e.idx, e.last);
                end
            end
            tick; n++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL mode0_timeout left=%0d want=0", sb.size()); sb.delete(); end
        total++; if (a_if.coeff_ready_o !== 1'b0 || a_if.poly_last_o !== 1'b0) begin
            bad++; $display("FAIL mode0_idle got valid=%0b last=%0b want 0/0", a_if.coeff_ready_o, a_if.poly_last_o);
        end
    endtask

    task automatic test_modes;
        exp_t e;
        for (int m = 1; m <= 2; m++) begin
            int n = 0;
            drive_a(vec_m1, 5, 21, m);
            if (m == 1) push_a(exp_m1); else push_a(exp_m2);
            a_if.coeff_ready_i = 1'b1;
            tick;
            a_if.coeff_ready_i = 1'b0;
            while (sb.size() != 0 && n < 40) begin
                if (a_if.coeff_ready_o) begin
                    e = sb.pop_front();
                    total++;
                    if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o} !== {e.v, e.idx, e.last}) begin
                        bad++; $display("FAIL mode%0d_beat got=%0d/idx%0d/last%0b want=%0d/idx%0d/last%0b", m,
                                        a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, e.v, e.idx, e.last);
                    end
                end
                tick; n++;
            end
            total++; if (sb.size() != 0) begin bad++; $display("FAIL mode%0d_timeout left=%0d want=0", m, sb.size()); sb.delete(); end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   beats = 0, bubbles = 0;
        bit   started = 0, ovf_ok = 1;
        push_a(exp_m0);
        push_a(exp_m2);
        a_if.coeff_ack_i = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (a_if.coeff_ready_o) begin
                started = 1;
                beats++;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL b2b_extra_beat got=%0d idx%0d want=no beat", a_if.coeff_o, a_if.coeff_idx_o);
                end else begin
                    e = sb.pop_front();
                    if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o} !== {e.v, e.idx, e.last}) begin
                        bad++; $display("FAIL b2b_beat got=%0d/idx%0d/last%0b want=%0d/idx%0d/last%0b",
                                        a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, e.v, e.idx, e.last);
                    end
                end
            end else if (started && sb.size() != 0) begin
                bubbles++;
            end
            if (cyc >= 3 && a_if.overflow_o !== 1'b1) ovf_ok = 0;
            case (cyc)
                0: begin drive_a(vec_m0, 0, 21, 0); a_if.coeff_ready_i = 1'b1; end
                1: begin drive_a(vec_m1, 0, 21, 2); a_if.coeff_ready_i = 1'b1; end
                2: begin
                    total++; if (a_if.in_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_in_ready got=%0b want=0", a_if.in_ready_o); end
                    drive_a(vec_m1, 5, 21, 1); a_if.coeff_ready_i = 1'b1;
                end
                3: begin a_if.coeff_ready_i = 1'b0; drive_a(vec_m0, 9, 7, 3); end
                default: ;
            endcase
            tick;
        end
        total++; if (beats != 16) begin bad++; $display("FAIL b2b_beats got=%0d want=16", beats); end
        total++; if (bubbles != 0) begin bad++; $display("FAIL b2b_bubbles got=%0d want=0", bubbles); end
        total++; if (!ovf_ok) begin bad++; $display("FAIL b2b_overflow_sticky got=dropped want=held 1"); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL b2b_missing left=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_backpressure;
        exp_t        e;
        logic [35:0] snap;
        bit          stalled = 0;
        int          n = 0;
        total++; if (a_if.overflow_o !== 1'b1) begin bad++; $display("FAIL bp_overflow_sticky got=%0b want=1", a_if.overflow_o); end
        drive_a(vec_m1, 5, 21, 1);
        push_a(exp_m1);
        a_if.coeff_ack_i   = 1'b1;
        a_if.coeff_ready_i = 1'b1;
        tick;
        a_if.coeff_ready_i = 1'b0;
        while (sb.size() != 0 && n < 60) begin
            if (a_if.coeff_ready_o && a_if.coeff_idx_o == 3'd3 && !stalled) begin
                stalled = 1;
                snap = {a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o};
                a_if.coeff_ack_i = 1'b0;
                repeat (3) begin
                    tick;
                    total++;
                    if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, a_if.coeff_ready_o} !== {snap, 1'b1}) begin
                        bad++; $display("FAIL bp_hold got=%0d/idx%0d/last%0b/vld%0b want=%0d/idx3/last0/vld1",
                                        a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, a_if.coeff_ready_o, snap[35:4]);
                    end
                end
                a_if.coeff_ack_i = 1'b1;
            end
            if (a_if.coeff_ready_o) begin
                e = sb.pop_front();
                total++;
                if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o} !== {e.v, e.idx, e.last}) begin
                    bad++; $display("FAIL bp_beat got=%0d/idx%0d/last%0b want=%0d/idx%0d/last%0b",
                                    a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, e.v, e.idx, e.last);
                end
            end
            tick; n++;
        end
        total++; if (!stalled) begin bad++; $display("FAIL bp_stall_point got=never saw idx3 want=stall at idx3"); end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_timeout left=%0d want=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_lanes2;
        exp2_t e;
        int    n = 0;
        for (int i = 0; i < 8; i++) b_if.coeff_i[i] = 32'(vec_m0[i]);
        b_if.t = 32'd0; b_if.q = 32'd21; b_if.mode_i = 2'd0;
        for (int k = 0; k < 4; k++)
            sb2.push_back('{v0: 32'(exp_m0[2*k]), v1: 32'(exp_m0[2*k+1]), idx: 3'(2*k), last: (k == 3)});
        b_if.coeff_ack_i   = 1'b1;
        b_if.coeff_ready_i = 1'b1;
        tick;
        b_if.coeff_ready_i = 1'b0;
        while (sb2.size() != 0 && n < 40) begin
            if (b_if.coeff_ready_o) begin
                e = sb2.pop_front();
                total++;
                if ({b_if.coeff_o[1], b_if.coeff_o[0], b_if.coeff_idx_o, b_if.poly_last_o} !== {e.v1, e.v0, e.idx, e.last}) begin
                    bad++; $display("FAIL lanes2_beat got={%0d,%0d}/idx%0d/last%0b want={%0d,%0d}/idx%0d/last%0b",
                                    b_if.coeff_o[0], b_if.coeff_o[1], b_if.coeff_idx_o, b_if.poly_last_o,
                                    e.v0, e.v1, e.idx, e.last);
                end
            end
            tick; n++;
        end
        total++; if (sb2.size() != 0) begin bad++; $display("FAIL lanes2_timeout left=%0d want=0", sb2.size()); sb2.delete(); end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        bit   hit = 0;
        int   n = 0;
        push_a(exp_m0);
        a_if.coeff_ack_i = 1'b1;
        while (!hit && n < 40) begin
            if (a_if.coeff_ready_o && a_if.coeff_idx_o == 3'd4) begin
                hit = 1;
            end else begin
                if (a_if.coeff_ready_o) begin
                    e = sb.pop_front();
                    total++;
                    if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o} !== {e.v, e.idx, e.last}) begin
                        bad++; $display("FAIL rstmid_beat got=%0d/idx%0d want=%0d/idx%0d",
                                        a_if.coeff_o, a_if.coeff_idx_o, e.v, e.idx);
                    end
                end
                a_if.coeff_ready_i = (n < 2);
                if (n < 2) drive_a(vec_m0, 0, 21, 0);
                tick; n++;
            end
        end
        total++; if (!hit) begin bad++; $display("FAIL rstmid_reach got=no idx4 want=idx4 beat"); end
        sb.delete();
        rst = 1'b1;
        a_if.coeff_ready_i = 1'b0;
        tick;
        total++; if ({a_if.coeff_ready_o, a_if.poly_last_o, a_if.coeff_o, a_if.coeff_idx_o} !== 36'd0) begin
            bad++; $display("FAIL rstmid_outputs got vld=%0b last=%0b coeff=%0d idx=%0d want all 0",
                            a_if.coeff_ready_o, a_if.poly_last_o, a_if.coeff_o, a_if.coeff_idx_o);
        end
        total++; if (a_if.in_ready_o !== 1'b1 || a_if.overflow_o !== 1'b0) begin
            bad++; $display("FAIL rstmid_flags got rdy=%0b ovf=%0b want rdy=1 ovf=0", a_if.in_ready_o, a_if.overflow_o);
        end
        rst = 1'b0;
        tick;
        total++; if (a_if.coeff_ready_o !== 1'b0) begin bad++; $display("FAIL rstmid_flushed got vld=%0b want=0", a_if.coeff_ready_o); end
        drive_a(vec_r, 0, 21, 0);
        push_a(vec_r);
        a_if.coeff_ready_i = 1'b1;
        tick;
        a_if.coeff_ready_i = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            if (a_if.coeff_ready_o) begin
                e = sb.pop_front();
                total++;
                if ({a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o} !== {e.v, e.idx, e.last}) begin
                    bad++; $display("FAIL rstmid_fresh got=%0d/idx%0d/last%0b want=%0d/idx%0d/last%0b",
                                    a_if.coeff_o, a_if.coeff_idx_o, a_if.poly_last_o, e.v, e.idx, e.last);
                end
            end
            tick; n++;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL rstmid_timeout left=%0d want=0", sb.size()); sb.delete(); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=still running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset;
        test_mode0;
        test_modes;
        test_back_to_back;
        test_backpressure;
        test_lanes2;
        test_reset_midstream;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poly_coeff_streamer.md
# poly_coeff_streamer

Parametrised successor to the single-rate coefficient datapath. It accepts whole polynomials as parallel coefficient vectors and holds up to two polynomials in a ping-pong buffer. Each coefficient gets one per-polynomial modular operation (reduce, add-t, or negate mod q). Results stream out LANES coefficients per beat under a valid/ack handshake, feeding downstream HE stages (NTT, key-switch) that need back-pressure.

## Interface
- BIT_WIDTH, 32: coefficient, t, q width.
- DEGREE_N, 8: coefficients per polynomial; ≥ 2.
- LANES, 1: coefficients per output beat; must divide DEGREE_N.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- t  in  BIT_WIDTH  addend for mode 1; captured at load.
- q  in  BIT_WIDTH  modulus, q ≥ 2; captured at load.
- mode_i  in  2  0 = reduce, 1 = add t, 2 = negate, 3 = reserved (acts as 0); captured at load.
- coeff_i  in  DEGREE_N×BIT_WIDTH  polynomial; element 0 is streamed first.
- coeff_ready_i  in  1  load strobe.
- in_ready_o  out  1  at least one buffer slot is free.
- overflow_o  out  1  sticky: a load strobe arrived while in_ready_o was 0.
- coeff_o  out  LANES×BIT_WIDTH  output beat; lane j carries coefficient idx+j.
- coeff_ready_o  out  1  coeff_o valid.
- coeff_ack_i  in  1  downstream accepts the beat.
- coeff_idx_o  out  log2(DEGREE_N) bits (minimum 1)  index of lane 0's coefficient.
- poly_last_o  out  1  current beat is the final beat of its polynomial.

## Operation
- Two slots. Each slot holds DEGREE_N coefficients plus the t, q and mode captured with them, and an occupied bit. There is a write pointer and a read pointer, each 1 bit.
- Load: when coeff_ready_i=1 and in_ready_o=1, the slot at the write pointer captures coeff_i, t, q and mode_i. That slot is marked occupied and the write pointer toggles.
- Dropped load: when coeff_ready_i=1 and in_ready_o=0, nothing is captured and overflow_o is set to 1. overflow_o clears only on rst.
- in_ready_o = NOT (both slots occupied). It is decoded from registered occupancy, so a slot freed this cycle becomes loadable in the next cycle.
- Read FSM:
  - IDLE: waits until the slot at the read pointer is occupied, then moves to STREAM with beat = 0.
  - STREAM: presents a beat from the slot at the read pointer.
  - On a handshake (coeff_ready_o and coeff_ack_i both 1) with a beat that is not the last, beat increments.
  - On a handshake with the last beat, the slot is freed and the read pointer toggles. If the other slot is occupied, the FSM stays in STREAM with beat = 0 and emits no bubble. Otherwise it returns to IDLE.
- Output register:
  - Loads when coeff_ready_o=0 or coeff_ack_i=1, provided a beat is available.
  - While coeff_ready_o=1 and coeff_ack_i=0, coeff_o, coeff_idx_o and poly_last_o hold stable.
- Arithmetic, per lane c, with a BIT_WIDTH+1 internal width:
  - Mode 0: c ≥ q ? c−q : c. Inputs must be < 2q.
  - Mode 1: s = c+t; s ≥ q ? s−q : s. Inputs must satisfy c, t < q.
  - Mode 2: c = 0 ? 0 : q−c. Input must be < q.
  - Inputs outside these ranges give implementation-defined results and raise no error.
- A simultaneous load into one slot and stream-out from the other is legal and independent.

## Timing
- Reset values:
  - in_ready_o = 1.
  - overflow_o, coeff_ready_o, poly_last_o = 0.
  - coeff_o and coeff_idx_o = 0.
  - Both slots empty, both pointers 0, FSM in IDLE.
- Latency: a load sampled at edge E0 into an idle block gives coeff_ready_o = 1 after edge E1, with beat 0.
- Throughput: one beat per cycle while coeff_ack_i=1. This holds across polynomial boundaries when both slots are filled.
- Beats per polynomial = DEGREE_N/LANES. poly_last_o = 1 exactly on beat DEGREE_N/LANES−1.
- Reset during STREAM flushes everything. After the reset edge all outputs are at their reset values. The next load streams from index 0.
- A mid-stream change on t, q or mode_i has no effect on polynomials already loaded.

## Test plan
- Mode 0, q=21, DEGREE_N=8, LANES=1, coeff {0,20,21,41,5,22,40,1}, ack held 1 -> coeff_o sequence {0,20,0,20,5,1,19,1}. First valid is after E1; poly_last_o is 1 only at idx 7.
- Mode 1, q=21, t=5, coeff {18,3,0,15,16,20,1,10} -> {2,8,5,20,0,4,6,15}. Mode 2 on the same vector -> {3,18,0,6,5,1,20,11}.
- Two loads on consecutive cycles, then a third load while both slots are occupied, with ack held 1:
  - Exactly 16 contiguous beats, with no bubble between idx 7 and the next idx 0.
  - The third polynomial never appears.
  - in_ready_o=0 in the third-load cycle.
  - overflow_o=1 from then until rst.
- Back-pressure: drop ack for 3 cycles at idx 3 -> coeff_o, coeff_idx_o and poly_last_o stable for those 3 cycles; the stream resumes at idx 3 with no loss or duplication.
- LANES=2, DEGREE_N=8, mode 0, q=21, coeff {0,20,21,41,5,22,40,1} -> 4 beats: {0,20} idx 0, {0,20} idx 2, {5,1} idx 4, {19,1} idx 6. poly_last_o is 1 on the idx 6 beat.
- rst asserted at idx 4 with a second polynomial queued -> all outputs reset next cycle and in_ready_o=1. A fresh load of {7,…} then streams 7 first at idx 0.
